// File: rtl/step_counter.sv
// step_counter: up/down counter with programmable step, inclusive upper limit,
//   wrap or saturate at the bounds, synchronous load, terminal-count pulse and
//   sticky overflow flag.
// Latency: one cycle from sampled inputs to out/tc/ovf; no input-to-output comb path.
// Backpressure: none; single-clock leaf driven by level enables from its parent.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset (out=RESET_VAL, tc=0, ovf=0)
//   en         step once per cycle while high
//   load       synchronous load of load_val, overrides en
//   load_val   value written on load (no range check against limit)
//   dir        1 = count up, 0 = count down
//   step       step magnitude, zero-extended to WIDTH
//   limit      inclusive unsigned upper bound, sampled every cycle
//   sat_mode   1 = saturate at the bounds, 0 = wrap to the opposite bound
//   clr_flags  synchronous clear of ovf (a same-cycle boundary event wins)
//   out        registered count
//   tc         registered one-cycle pulse following a boundary event
//   ovf        sticky flag, set by any boundary event

module step_counter #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned STEP_W    = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              dir,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              sat_mode,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  out,
   output logic              tc,
   output logic              ovf
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             ovf_q;

   logic [WIDTH-1:0] count_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;

   // ------------------------------------------------------------------
   // Step arithmetic
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] step_ext;
   logic             step_nz;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH-1:0] dn_diff;
   logic             up_evt;
   logic             dn_evt;
   logic             evt;

   // Size cast zero-extends the unsigned step; also legal when STEP_W == WIDTH.
   assign step_ext = WIDTH'(step);
   assign step_nz  = |step;

   // The extra sum bit keeps the carry, so a wrap past 2^WIDTH and a count
   // already above limit (after a load) both show up as sum > limit.
   assign up_sum  = {1'b0, count_q} + {1'b0, step_ext};
   assign dn_diff = count_q - step_ext;

   // A zero step never passes a bound, even when count sits above limit.
   assign up_evt = step_nz && (up_sum > {1'b0, limit});
   assign dn_evt = count_q < step_ext;

   assign evt = en && !load && (dir ? up_evt : dn_evt);

   // ------------------------------------------------------------------
   // Next-state logic: load > en > hold
   // ------------------------------------------------------------------
   always_comb begin
      count_nxt = count_q;
      tc_nxt    = 1'b0;

      if (load) begin
         count_nxt = load_val;
      end else if (en) begin
         if (dir) begin
            if (up_evt) begin
               count_nxt = sat_mode ? limit : '0;
               tc_nxt    = 1'b1;
            end else begin
               count_nxt = up_sum[WIDTH-1:0];
            end
         end else begin
            if (dn_evt) begin
               count_nxt = sat_mode ? '0 : limit;
               tc_nxt    = 1'b1;
            end else begin
               count_nxt = dn_diff;
            end
         end
      end
   end

   // Event has priority over the clear so a same-cycle event is never lost.
   always_comb begin
      ovf_nxt = ovf_q;
      if (evt) begin
         ovf_nxt = 1'b1;
      end else if (clr_flags) begin
         ovf_nxt = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= RESET_VAL;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         tc_q    <= tc_nxt;
         ovf_q   <= ovf_nxt;
      end
   end

   assign out = count_q;
   assign tc  = tc_q;
   assign ovf = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: directed vectors for step_counter (WIDTH=8, RESET_VAL=5)
//   with hand-computed expected out/tc/ovf after each clock edge.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_step_counter;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned STEP_W = 8;

   logic              clk;
   logic              rst;
   logic              en;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic              dir;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  limit;
   logic              sat_mode;
   logic              clr_flags;
   logic [WIDTH-1:0]  out;
   logic              tc;
   logic              ovf;

   int vec_cnt;
   int err_cnt;

   step_counter #(
      .WIDTH     (WIDTH),
      .STEP_W    (STEP_W),
      .RESET_VAL (8'd5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .load_val  (load_val),
      .dir       (dir),
      .step      (step),
      .limit     (limit),
      .sat_mode  (sat_mode),
      .clr_flags (clr_flags),
      .out       (out),
      .tc        (tc),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check all three outputs at once.
   task automatic chk3(input string tag, input logic [7:0] e_out, input logic e_tc, input logic e_ovf);
      chk({tag, ".out"}, 32'(out), 32'(e_out));
      chk({tag, ".tc"},  32'(tc),  32'(e_tc));
      chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
   endtask

   initial begin
      vec_cnt   = 0;
      err_cnt   = 0;
      rst       = 1'b1;
      en        = 1'b0;
      load      = 1'b0;
      load_val  = '0;
      dir       = 1'b1;
      step      = 8'd1;
      limit     = 8'd100;
      sat_mode  = 1'b0;
      clr_flags = 1'b0;

      // Asynchronous reset asserted mid-cycle takes effect at once.
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk3("rst_async", 8'd5, 1'b0, 1'b0);
      tick();
      chk3("rst_hold", 8'd5, 1'b0, 1'b0);

      // Release with up-count step 1: 6, 7, 8.
      en = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      tick(); chk("rel_cnt0", 32'(out), 32'd6);
      tick(); chk("rel_cnt1", 32'(out), 32'd7);
      tick(); chk("rel_cnt2", 32'(out), 32'd8);

      // Up wrap: 98 -> 100 (no event) -> 0 (event) -> 2.
      load = 1'b1; load_val = 8'd98; step = 8'd2;
      tick(); chk3("wrap_load", 8'd98, 1'b0, 1'b0);
      load = 1'b0;
      tick(); chk3("wrap_at_lim", 8'd100, 1'b0, 1'b0);
      tick(); chk3("wrap_evt", 8'd0, 1'b1, 1'b1);
      tick(); chk3("wrap_after", 8'd2, 1'b0, 1'b1);

      // clr_flags alone clears ovf.
      en = 1'b0; clr_flags = 1'b1;
      tick(); chk3("clr_alone", 8'd2, 1'b0, 1'b0);
      clr_flags = 1'b0;

      // Down saturate: 3 -> 1 -> 0 (event), holding at 0 keeps tc high.
      load = 1'b1; load_val = 8'd3; dir = 1'b0; sat_mode = 1'b1; en = 1'b1;
      tick(); chk3("dsat_load", 8'd3, 1'b0, 1'b0);
      load = 1'b0;
      tick(); chk3("dsat_step", 8'd1, 1'b0, 1'b0);
      tick(); chk3("dsat_evt", 8'd0, 1'b1, 1'b1);
      tick(); chk3("dsat_hold0", 8'd0, 1'b1, 1'b1);
      clr_flags = 1'b1;   // event in the same cycle wins over the clear
      tick(); chk3("clr_vs_evt", 8'd0, 1'b1, 1'b1);
      en = 1'b0;
      tick(); chk3("clr_next", 8'd0, 1'b0, 1'b0);
      clr_flags = 1'b0;

      // load overrides en.
      load = 1'b1; en = 1'b1; load_val = 8'd42; dir = 1'b1; step = 8'd2; sat_mode = 1'b0;
      tick(); chk3("ld_over_en", 8'd42, 1'b0, 1'b0);

      // Carry out of 8 bits with limit 255: 250 + 10 wraps to 0.
      limit = 8'd255; load_val = 8'd250; step = 8'd10;
      tick(); chk("carry_load", 32'(out), 32'd250);
      load = 1'b0;
      tick(); chk3("carry_up", 8'd0, 1'b1, 1'b1);

      // Borrow: 4 - 10 wraps to limit 255.
      load = 1'b1; load_val = 8'd4; dir = 1'b0;
      tick(); chk3("borrow_load", 8'd4, 1'b0, 1'b1);
      load = 1'b0;
      tick(); chk3("borrow_dn", 8'd255, 1'b1, 1'b1);

      // step = 0 holds with no event for 4 cycles.
      load = 1'b1; load_val = 8'd77; dir = 1'b1; limit = 8'd100;
      tick();
      load = 1'b0; step = 8'd0;
      for (int i = 0; i < 4; i++) begin
         tick(); chk3($sformatf("step0_%0d", i), 8'd77, 1'b0, 1'b1);
      end

      // Loaded above limit: step 0 is still not an event.
      load = 1'b1; load_val = 8'd200;
      tick();
      load = 1'b0;
      tick(); chk3("above_step0", 8'd200, 1'b0, 1'b1);

      // Loaded above limit, step up 1: wrap gives 0, saturate gives limit.
      step = 8'd1;
      tick(); chk3("above_wrap", 8'd0, 1'b1, 1'b1);
      load = 1'b1; sat_mode = 1'b1;
      tick();
      load = 1'b0;
      tick(); chk3("above_sat", 8'd100, 1'b1, 1'b1);

      // Up count reaching limit exactly under saturate is not an event.
      load = 1'b1; load_val = 8'd97; step = 8'd3;
      tick();
      load = 1'b0;
      tick(); chk3("sat_exact", 8'd100, 1'b0, 1'b1);
      tick(); chk3("sat_pass", 8'd100, 1'b1, 1'b1);

      // Reset mid-count discards state, including ovf.
      #2;
      rst = 1'b0;
      #1;
      chk3("rst_mid", 8'd5, 1'b0, 1'b0);
      tick(); chk3("rst_mid_hold", 8'd5, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
